// File: rtl/scan_cfg_loader_if.sv
// Byte stream into the loader and readback byte stream out of it.
interface scan_cfg_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] rd_data;
  logic       rd_valid;

  modport master (
    output in_data, in_valid,
    input  in_ready, rd_data, rd_valid
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/scan_cfg_loader.sv
// Serialises configuration bytes into the fabric scan chain, captures the
// returning chain bits as readback bytes and commits with latch/ff gate pulses.
module scan_cfg_loader #(
  parameter int unsigned CHAIN_LEN = 256,
  parameter int unsigned CNT_W     = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               load_ff,
  input  logic               scan_ret,
  scan_cfg_loader_if.slave   bus,
  output logic               se,
  output logic               sc,
  output logic               l_gate,
  output logic               ff_gate,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SHIFT  = 3'd1;
  localparam logic [2:0] LATCH  = 3'd2;
  localparam logic [2:0] FFGATE = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  logic [2:0]       state, state_n;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [7:0]       shbuf, shbuf_n;
  logic [3:0]       fill, fill_n;
  logic             ff_flag, ff_flag_n;
  logic [7:0]       rb, rb_n;
  logic [3:0]       rb_cnt, rb_cnt_n;
  logic [7:0]       rd_data_n;
  logic             rd_valid_n;
  logic             se_n, sc_n;

  logic             shift_c;
  logic             last_c;
  logic             accept_c;
  logic [7:0]       rb_shift_c;
  logic [3:0]       rb_cnt_inc_c;

  // A bit is shifted whenever the buffer holds one; the final chain bit ends the shift phase.
  assign shift_c      = (state == SHIFT) && (fill != 4'd0);
  assign last_c       = shift_c && (bit_cnt == LAST_BIT);
  assign rb_shift_c   = {scan_ret, rb[7:1]};
  assign rb_cnt_inc_c = rb_cnt + 4'd1;

  // Refill when the buffer empties this cycle; never take a byte on the final chain bit.
  assign bus.in_ready = (state == SHIFT) && !last_c &&
                        ((fill == 4'd0) || ((fill == 4'd1) && shift_c));
  assign accept_c     = bus.in_ready && bus.in_valid;

  // Next-state, datapath and readback assembly.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shbuf_n    = shbuf;
    fill_n     = fill;
    ff_flag_n  = ff_flag;
    rb_n       = rb;
    rb_cnt_n   = rb_cnt;
    rd_data_n  = bus.rd_data;
    rd_valid_n = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n   = SHIFT;
          bit_cnt_n = '0;
          fill_n    = 4'd0;
          rb_n      = 8'd0;
          rb_cnt_n  = 4'd0;
          ff_flag_n = load_ff;
        end
      end
      SHIFT: begin
        if (shift_c) begin
          shbuf_n   = shbuf >> 1;
          fill_n    = fill - 4'd1;
          bit_cnt_n = bit_cnt + CNT_W'(1);
          rb_n      = rb_shift_c;
          rb_cnt_n  = rb_cnt_inc_c;
          // Full byte, or the right-justified remainder at the chain end.
          if ((rb_cnt_inc_c == 4'd8) || last_c) begin
            rd_valid_n = 1'b1;
            rd_data_n  = rb_shift_c >> (4'd8 - rb_cnt_inc_c);
            rb_cnt_n   = 4'd0;
          end
        end
        if (accept_c) begin
          shbuf_n = bus.in_data;
          fill_n  = 4'd8;
        end
        if (last_c) begin
          state_n = LATCH;
          fill_n  = 4'd0;
        end
      end
      LATCH:   state_n = ff_flag ? FFGATE : DONE;
      FFGATE:  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (abort && (state != IDLE)) begin
      state_n    = IDLE;
      fill_n     = 4'd0;
      rb_cnt_n   = 4'd0;
      rd_valid_n = 1'b0;
    end

    se_n = (state_n == SHIFT) && (fill_n != 4'd0);
    sc_n = se_n && shbuf_n[0];
  end

  // State, datapath and registered fabric-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shbuf        <= 8'd0;
      fill         <= 4'd0;
      ff_flag      <= 1'b0;
      rb           <= 8'd0;
      rb_cnt       <= 4'd0;
      bus.rd_data  <= 8'd0;
      bus.rd_valid <= 1'b0;
      se           <= 1'b0;
      sc           <= 1'b0;
      l_gate       <= 1'b0;
      ff_gate      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      shbuf        <= shbuf_n;
      fill         <= fill_n;
      ff_flag      <= ff_flag_n;
      rb           <= rb_n;
      rb_cnt       <= rb_cnt_n;
      bus.rd_data  <= rd_data_n;
      bus.rd_valid <= rd_valid_n;
      se           <= se_n;
      sc           <= sc_n;
      l_gate       <= (state_n == LATCH);
      ff_gate      <= (state_n == FFGATE);
      busy         <= (state_n != IDLE);
      done         <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_scan_cfg_loader.sv
// Directed bench for scan_cfg_loader: a 16-bit and a 12-bit chain instance.
module tb_scan_cfg_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       load_ff = 1'b0;
  logic       scan_ret = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       sel = 1'b0;

  always #5 clk = ~clk;

  scan_cfg_loader_if ifa ();
  scan_cfg_loader_if ifb ();

  assign ifa.in_data  = in_data;
  assign ifa.in_valid = in_valid;
  assign ifb.in_data  = in_data;
  assign ifb.in_valid = in_valid;

  logic se_a, sc_a, lg_a, fg_a, busy_a, done_a;
  logic se_b, sc_b, lg_b, fg_b, busy_b, done_b;

  scan_cfg_loader #(.CHAIN_LEN(16), .CNT_W(5)) dut_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .abort(abort & ~sel),
    .load_ff(load_ff), .scan_ret(scan_ret), .bus(ifa),
    .se(se_a), .sc(sc_a), .l_gate(lg_a), .ff_gate(fg_a), .busy(busy_a), .done(done_a)
  );

  scan_cfg_loader #(.CHAIN_LEN(12), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start & sel), .abort(abort & sel),
    .load_ff(load_ff), .scan_ret(scan_ret), .bus(ifb),
    .se(se_b), .sc(sc_b), .l_gate(lg_b), .ff_gate(fg_b), .busy(busy_b), .done(done_b)
  );

  // Observe the selected instance.
  logic       obs_se, obs_sc, obs_lg, obs_fg, obs_busy, obs_done, obs_rdv, obs_rdy;
  logic [7:0] obs_rdd;
  assign obs_se   = sel ? se_b   : se_a;
  assign obs_sc   = sel ? sc_b   : sc_a;
  assign obs_lg   = sel ? lg_b   : lg_a;
  assign obs_fg   = sel ? fg_b   : fg_a;
  assign obs_busy = sel ? busy_b : busy_a;
  assign obs_done = sel ? done_b : done_a;
  assign obs_rdv  = sel ? ifb.rd_valid : ifa.rd_valid;
  assign obs_rdd  = sel ? ifb.rd_data  : ifa.rd_data;
  assign obs_rdy  = sel ? ifb.in_ready : ifa.in_ready;

  int n_checks = 0;
  int n_errors = 0;

  // Per-load observations.
  logic [31:0] sc_bits;
  logic [7:0]  rd_v [2];
  int k, nl, nff, nd, nrd;
  int first_c, last_c, lg_c, ff_c, done_c, rd0_c, rdl_c, abort_c, end_c;
  bit finished;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start one load on the selected instance, stream bytes and act as the fabric.
  task automatic run_load(input logic [15:0] bytes_v, input logic [15:0] ret_v,
                          input int n_bytes, input bit do_stall, input int abort_k,
                          input bit ff);
    int  bi;
    int  st;
    bit  seen;
    bit  stall_now;
    bi = 0; st = 0; seen = 0;
    k = 0; nl = 0; nff = 0; nd = 0; nrd = 0;
    sc_bits = 32'd0; rd_v[0] = 8'd0; rd_v[1] = 8'd0;
    first_c = -1; last_c = -1; lg_c = -1; ff_c = -1; done_c = -1;
    rd0_c = -1; rdl_c = -1; abort_c = -1; end_c = -1; finished = 0;
    load_ff = ff;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 200 && !finished; c++) begin
      abort = 1'b0;
      if (obs_se) begin
        sc_bits[k] = obs_sc;
        scan_ret   = (k < 16) ? ret_v[k] : 1'b0;
        if (first_c < 0) first_c = c;
        last_c = c;
        k++;
      end else begin
        scan_ret = 1'b0;
      end
      if (obs_lg)   begin nl++;  lg_c = c;   end
      if (obs_fg)   begin nff++; ff_c = c;   end
      if (obs_done) begin nd++;  done_c = c; end
      if (obs_rdv) begin
        if (nrd < 2) rd_v[nrd] = obs_rdd;
        if (nrd == 0) rd0_c = c;
        rdl_c = c;
        nrd++;
      end
      if (abort_k > 0 && obs_se && k == abort_k) begin
        abort = 1'b1;
        abort_c = c;
      end
      stall_now = do_stall && (bi == 1) && (k >= 8) && (st < 3);
      if (stall_now) st++;
      if (bi < n_bytes && !stall_now) begin
        in_valid = 1'b1;
        in_data  = (bi == 0) ? bytes_v[7:0] : bytes_v[15:8];
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && obs_rdy) bi++;
      if (obs_busy) seen = 1;
      else if (seen) begin
        finished = 1;
        end_c = c;
      end
      if (!finished) @(negedge clk);
    end
    in_valid = 1'b0; abort = 1'b0; scan_ret = 1'b0;
  endtask

  task automatic check_full(input string pfx, input logic [31:0] exp_sc, input int nbits,
                            input bit exp_ff, input logic [7:0] e0, input logic [7:0] e1,
                            input int exp_stall);
    check({pfx, "_end"},     32'(finished), 32'd1);
    check({pfx, "_nse"},     k, nbits);
    check({pfx, "_sc"},      sc_bits, exp_sc);
    check({pfx, "_lg_n"},    nl, 1);
    check({pfx, "_lg_t"},    lg_c, last_c + 1);
    check({pfx, "_ff_n"},    nff, exp_ff ? 1 : 0);
    if (exp_ff) begin
      check({pfx, "_ff_t"},   ff_c, lg_c + 1);
      check({pfx, "_done_t"}, done_c, ff_c + 1);
    end else begin
      check({pfx, "_done_t"}, done_c, lg_c + 1);
    end
    check({pfx, "_done_n"},  nd, 1);
    check({pfx, "_rd_n"},    nrd, 2);
    check({pfx, "_rd0"},     rd_v[0], e0);
    check({pfx, "_rd1"},     rd_v[1], e1);
    check({pfx, "_rd0_t"},   rd0_c, first_c + 8);
    check({pfx, "_rdl_t"},   rdl_c, lg_c);
    check({pfx, "_stall"},   last_c - first_c + 1 - k, exp_stall);
  endtask

  initial begin
    // Reset values on both instances.
    repeat (2) @(negedge clk);
    sel = 1'b0; #1;
    check("reset_a", {23'd0, obs_se, obs_sc, obs_lg, obs_fg, obs_busy, obs_done, obs_rdv, obs_rdy, obs_rdd != 8'd0}, 32'd0);
    sel = 1'b1; #1;
    check("reset_b", {23'd0, obs_se, obs_sc, obs_lg, obs_fg, obs_busy, obs_done, obs_rdv, obs_rdy, obs_rdd != 8'd0}, 32'd0);
    @(negedge clk); rst = 1'b0; sel = 1'b0;

    // Byte offered while idle is not taken.
    @(negedge clk); in_valid = 1'b1; in_data = 8'h55; #1;
    check("idle_in_ready", 32'(obs_rdy), 32'd0);
    in_valid = 1'b0;

    // 16-bit chain, continuous stream, readback F0 / 81.
    run_load(16'h3CA5, 16'h81F0, 2, 1'b0, 0, 1'b0);
    check_full("basic", 32'h3CA5, 16, 1'b0, 8'hF0, 8'h81, 0);

    // Same load with a 3-cycle in_valid gap between bytes.
    run_load(16'h3CA5, 16'h81F0, 2, 1'b1, 0, 1'b0);
    check_full("stall", 32'h3CA5, 16, 1'b0, 8'hF0, 8'h81, 3);

    // 12-bit chain with ff gate, partial readback byte 0x0D.
    sel = 1'b1;
    run_load(16'h0FFF, 16'h0D5A, 2, 1'b0, 0, 1'b1);
    check_full("chain12", 32'h0FFF, 12, 1'b1, 8'h5A, 8'h0D, 0);
    sel = 1'b0;

    // Abort after 5 shift cycles, then a clean load.
    run_load(16'h3CA5, 16'h81F0, 2, 1'b0, 5, 1'b1);
    check("abort_end",   32'(finished), 32'd1);
    check("abort_nse",   k, 5);
    check("abort_idle_t", end_c, abort_c + 1);
    check("abort_gates", nl + nff + nd + nrd, 0);
    run_load(16'h3CA5, 16'h81F0, 2, 1'b0, 0, 1'b0);
    check_full("post_abort", 32'h3CA5, 16, 1'b0, 8'hF0, 8'h81, 0);

    // start and abort together in IDLE: stays idle.
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 32'(obs_busy), 32'd0);

    // Asynchronous reset in the middle of shifting.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
    repeat (4) @(negedge clk);
    check("pre_rst_se", 32'(obs_se), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_async", {26'd0, obs_se, obs_sc, obs_lg, obs_fg, obs_busy, obs_done}, 32'd0);
    start = 1'b1;
    repeat (2) @(negedge clk);
    check("start_in_rst", 32'(obs_busy), 32'd0);
    start = 1'b0; in_valid = 1'b0; rst = 1'b0;
    run_load(16'h3CA5, 16'h81F0, 2, 1'b0, 0, 1'b0);
    check_full("post_rst", 32'h3CA5, 16, 1'b0, 8'hF0, 8'h81, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/scan_cfg_loader.md
# scan_cfg_loader

Bitstream loader that sits directly upstream of the rotatable-FPGA fabric's configuration scan chain. Accepts configuration bytes over a valid/ready stream and shifts them serially into the fabric's scan input, one bit per clock. It captures the bits returning on the fabric's scan output as readback bytes, then pulses the latch gate to commit the new configuration. Drives the fabric's scan-enable, scan-in and latch-gate inputs; reads its scan-out.

## Interface
- CHAIN_LEN, 256: scan chain length in bits; legal range 1..4095.
- CNT_W, 12: width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

- clk  in  1  single clock; fabric scan chain shifts on the same edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE.
- abort  in  1  return to IDLE immediately; no latch pulse.
- load_ff  in  1  sampled at start; also pulse ff_gate after l_gate.
- in_data  in  8  configuration byte, LSB shifted first.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted on a cycle with in_valid && in_ready.
- scan_ret  in  1  fabric scan-out return bit.
- se  out  1  scan enable to fabric.
- sc  out  1  scan data to fabric.
- l_gate  out  1  latch-gate pulse to fabric.
- ff_gate  out  1  flip-flop-gate pulse to fabric.
- rd_data  out  8  readback byte, LSB = first returned bit.
- rd_valid  out  1  one-cycle strobe per readback byte; no backpressure.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on successful completion.

## Operation
- States: IDLE, SHIFT, LATCH, FFGATE, DONE.
- All outputs are registered, except in_ready. Reset value of every output is 0; state resets to IDLE and all counters and buffers reset to 0.
- IDLE to SHIFT on start. The bit counter clears and load_ff is captured into a flag.
- SHIFT:
  - Holds an 8-bit shift buffer with a 4-bit fill count.
  - A cycle with a bit available (fill > 0) is a shift cycle: se=1, sc=buffer[0], buffer shifts right, fill decrements, bit counter increments.
  - A cycle with no bit available is a stall: se=0, sc=0.
  - in_ready is high in SHIFT when fill==0, or when fill==1 and the current cycle is a shift cycle. An accepted byte loads the buffer with fill=8.
- Readback:
  - On each shift cycle, scan_ret is shifted into the readback register MSB-down.
  - On every 8th returned bit, rd_data/rd_valid are presented the next cycle.
- Chain end: when the bit counter reaches CHAIN_LEN, the state moves to LATCH.
  - The unused buffer bits are discarded.
  - A partial readback byte is emitted right-justified (upper bits 0) in the same cycle LATCH is entered.
- LATCH: l_gate=1 for exactly one cycle. Next state is FFGATE if the load_ff flag is set, else DONE.
- FFGATE: ff_gate=1 for one cycle, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- abort (any state except IDLE): next state IDLE, se/l_gate/ff_gate=0 next cycle, no done, pending partial readback byte dropped. abort has priority over every other transition.
- start while busy is ignored. start and abort in the same IDLE cycle: abort wins and the block stays IDLE.
- in_valid outside SHIFT: in_ready=0, the byte is not consumed.

## Timing
- Byte accepted in cycle N: its bit 0 appears on sc/se in cycle N+1. With in_valid held high, throughput is 1 bit/cycle with no inter-byte bubble.
- Total load (no stalls): 1 cycle (start) + CHAIN_LEN shift cycles + 1 LATCH + (1 FFGATE) + 1 DONE.
- scan_ret is sampled in the same cycle se=1 is driven. The fabric presents its oldest chain bit combinationally on scan_ret during each shift cycle.
- rd_valid occurs one cycle after the 8th contributing shift cycle.
- Asynchronous rst mid-operation: all outputs drop to 0 immediately, and the fabric sees no further se or gate pulses.

## Test plan
- CHAIN_LEN=16, start, stream 0xA5 then 0x3C with in_valid held high -> sc over 16 consecutive se=1 cycles = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; l_gate 1 cycle later; done 1 cycle after that; ff_gate never asserted.
- Same stimulus with scan_ret driven as 0xF0 then 0x81 (LSB first) -> rd_valid twice, rd_data=0xF0 then 0x81.
- CHAIN_LEN=12, load_ff=1, bytes 0xFF and 0x0F -> exactly 12 shift cycles; partial readback byte with bits [7:4]=0; l_gate then ff_gate on consecutive cycles, then done.
- in_valid deasserted for 3 cycles mid-byte-stream -> se=0 for those 3 cycles; bit counter holds; the final sc sequence is identical to the no-stall case.
- abort asserted after 5 shift cycles -> IDLE next cycle; l_gate, ff_gate and done never pulse; a following start runs a full load correctly.
- rst asserted mid-SHIFT -> all outputs 0 immediately; start ignored while rst is high; start after release begins from bit 0.
